// File: rtl/axis_video_frame_checker.sv
// AXI4-Stream video frame checker with a 2-entry skid register slice.
//
// The stream is forwarded unmodified with one cycle of latency. In parallel, a
// two-state FSM watches the input handshakes and raises sticky error flags for
// missing/early SOF (tuser) and early/late EOL (tlast).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_video_in_*               upstream stream (tuser = SOF, tlast = EOL)
//   m_axis_video_out_*              downstream stream
//   clear_errors                    single-cycle clear of the sticky error flags
//   err_missing_sof, err_early_sof  sticky error flags
//   err_early_eol, err_late_eol     sticky error flags
//   frame_done                      one-cycle pulse per completed frame
//   frame_count                     completed frames, wraps at 16 bits
module axis_video_frame_checker #(
    parameter int unsigned IMAGE_WIDTH    = 960,
    parameter int unsigned IMAGE_HEIGHT   = 540,
    parameter int unsigned PIXEL_PER_CLK  = 1,
    parameter int unsigned BITS_PER_PIXEL = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]   s_axis_video_in_tdata,
    input  logic                                      s_axis_video_in_tvalid,
    input  logic                                      s_axis_video_in_tlast,
    input  logic                                      s_axis_video_in_tuser,
    output logic                                      s_axis_video_in_tready,
    output logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0]   m_axis_video_out_tdata,
    output logic                                      m_axis_video_out_tvalid,
    output logic                                      m_axis_video_out_tlast,
    output logic                                      m_axis_video_out_tuser,
    input  logic                                      m_axis_video_out_tready,
    input  logic                                      clear_errors,
    output logic                                      err_missing_sof,
    output logic                                      err_early_sof,
    output logic                                      err_early_eol,
    output logic                                      err_late_eol,
    output logic                                      frame_done,
    output logic [15:0]                               frame_count
);

    localparam int unsigned DW    = BITS_PER_PIXEL * PIXEL_PER_CLK;
    localparam int unsigned BEATS = IMAGE_WIDTH / PIXEL_PER_CLK;
    localparam int unsigned XW    = $clog2(BEATS + 1);
    localparam int unsigned YW    = $clog2((IMAGE_HEIGHT > 1) ? IMAGE_HEIGHT : 2);

    // ------------------------------------------------------------------
    // Skid register slice
    // ------------------------------------------------------------------
    logic [DW-1:0] out_data_q, skid_data_q;
    logic          out_valid_q, out_last_q, out_user_q;
    logic          skid_valid_q, skid_last_q, skid_user_q;
    logic          ready_q;
    logic          in_hs;
    logic          out_free;

    assign in_hs    = s_axis_video_in_tvalid & ready_q;
    assign out_free = ~out_valid_q | m_axis_video_out_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_user_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid_q) begin
                    // Skid full implies ready_q was low, so no new beat this cycle.
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_last_q   <= skid_last_q;
                    out_user_q   <= skid_user_q;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else if (in_hs) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= s_axis_video_in_tdata;
                    out_last_q  <= s_axis_video_in_tlast;
                    out_user_q  <= s_axis_video_in_tuser;
                    ready_q     <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            end else if (in_hs) begin
                // Output stalled: park the accepted beat and stop accepting.
                skid_valid_q <= 1'b1;
                skid_data_q  <= s_axis_video_in_tdata;
                skid_last_q  <= s_axis_video_in_tlast;
                skid_user_q  <= s_axis_video_in_tuser;
                ready_q      <= 1'b0;
            end else begin
                ready_q <= ~skid_valid_q;
            end
        end
    end

    assign s_axis_video_in_tready  = ready_q;
    assign m_axis_video_out_tvalid = out_valid_q;
    assign m_axis_video_out_tdata  = out_data_q;
    assign m_axis_video_out_tlast  = out_last_q;
    assign m_axis_video_out_tuser  = out_user_q;

    // ------------------------------------------------------------------
    // Frame checker FSM
    // ------------------------------------------------------------------
    typedef enum logic {StWaitSof, StInFrame} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, idx;
    logic [YW-1:0]   y_q, y_d, line;
    logic            set_missing_sof, set_early_sof, set_early_eol, set_late_eol;
    logic            frame_close;
    logic            err_missing_sof_q, err_early_sof_q, err_early_eol_q, err_late_eol_q;
    logic            frame_done_q;
    logic [15:0]     frame_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    // A beat is ignored only when it arrives outside a frame without SOF.
    always_comb begin
        state_d = state_q;
        if (in_hs && !(state_q == StWaitSof && !s_axis_video_in_tuser)) begin
            state_d = frame_close ? StWaitSof : StInFrame;
        end
    end

    always_comb begin
        // SOF always restarts the position at beat 0 of line 0.
        idx             = s_axis_video_in_tuser ? '0 : x_q;
        line            = s_axis_video_in_tuser ? '0 : y_q;
        x_d             = x_q;
        y_d             = y_q;
        set_missing_sof = 1'b0;
        set_early_sof   = 1'b0;
        set_early_eol   = 1'b0;
        set_late_eol    = 1'b0;
        frame_close     = 1'b0;
        if (in_hs) begin
            if (state_q == StWaitSof && !s_axis_video_in_tuser) begin
                set_missing_sof = 1'b1;
            end else begin
                set_early_sof = (state_q == StInFrame) & s_axis_video_in_tuser;
                if (s_axis_video_in_tlast) begin
                    set_early_eol = (idx < XW'(BEATS - 1));
                    set_late_eol  = (idx > XW'(BEATS - 1));
                    x_d           = '0;
                    if (line == YW'(IMAGE_HEIGHT - 1)) begin
                        y_d         = '0;
                        frame_close = 1'b1;
                    end else begin
                        y_d = line + YW'(1);
                    end
                end else begin
                    set_late_eol = (idx == XW'(BEATS - 1));
                    x_d          = (idx == XW'(BEATS)) ? idx : idx + XW'(1);
                    y_d          = line;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q               <= '0;
            y_q               <= '0;
            err_missing_sof_q <= 1'b0;
            err_early_sof_q   <= 1'b0;
            err_early_eol_q   <= 1'b0;
            err_late_eol_q    <= 1'b0;
            frame_done_q      <= 1'b0;
            frame_count_q     <= '0;
        end else begin
            x_q               <= x_d;
            y_q               <= y_d;
            // A new error wins over a simultaneous clear.
            err_missing_sof_q <= (err_missing_sof_q & ~clear_errors) | set_missing_sof;
            err_early_sof_q   <= (err_early_sof_q & ~clear_errors) | set_early_sof;
            err_early_eol_q   <= (err_early_eol_q & ~clear_errors) | set_early_eol;
            err_late_eol_q    <= (err_late_eol_q & ~clear_errors) | set_late_eol;
            frame_done_q      <= frame_close;
            if (frame_close) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign err_missing_sof = err_missing_sof_q;
    assign err_early_sof   = err_early_sof_q;
    assign err_early_eol   = err_early_eol_q;
    assign err_late_eol    = err_late_eol_q;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_axis_video_frame_checker.sv
module tb_axis_video_frame_checker;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int PPC = 2;
    localparam int BPP = 8;
    localparam int DW  = BPP * PPC;
    localparam int B   = W / PPC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;
    logic          clear_errors = 1'b0;
    logic          err_missing_sof, err_early_sof, err_early_eol, err_late_eol;
    logic          frame_done;
    logic [15:0]   frame_count;

    axis_video_frame_checker #(
        .IMAGE_WIDTH   (W),
        .IMAGE_HEIGHT  (H),
        .PIXEL_PER_CLK (PPC),
        .BITS_PER_PIXEL(BPP)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_video_in_tdata  (s_tdata),
        .s_axis_video_in_tvalid (s_tvalid),
        .s_axis_video_in_tlast  (s_tlast),
        .s_axis_video_in_tuser  (s_tuser),
        .s_axis_video_in_tready (s_tready),
        .m_axis_video_out_tdata (m_tdata),
        .m_axis_video_out_tvalid(m_tvalid),
        .m_axis_video_out_tlast (m_tlast),
        .m_axis_video_out_tuser (m_tuser),
        .m_axis_video_out_tready(m_tready),
        .clear_errors           (clear_errors),
        .err_missing_sof        (err_missing_sof),
        .err_early_sof          (err_early_sof),
        .err_early_eol          (err_early_eol),
        .err_late_eol           (err_late_eol),
        .frame_done             (frame_done),
        .frame_count            (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected output beats plus frame position and error state.
    logic [DW+1:0] exp_q[$];
    bit            m_in;
    int            bx, ly, frames;
    bit            e_miss, e_sof, e_eeol, e_leol;
    bit            fd_pending, stalled, lat_pend;
    logic [DW+1:0] stall_beat, lat_beat, beat, got_beat;
    int            rmode = 0;

    function automatic void model_beat(input bit u, input bit l);
        if (!m_in && !u) begin
            e_miss = 1'b1;
            return;
        end
        if (u) begin
            if (m_in) e_sof = 1'b1;
            m_in = 1'b1;
            bx   = 0;
            ly   = 0;
        end
        if (l) begin
            if (bx < B - 1) e_eeol = 1'b1;
            if (bx > B - 1) e_leol = 1'b1;
            bx = 0;
            ly++;
            if (ly == H) begin
                ly         = 0;
                m_in       = 1'b0;
                frames++;
                fd_pending = 1'b1;
            end
        end else begin
            if (bx == B - 1) e_leol = 1'b1;
            if (bx < B) bx++;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_in = 0; bx = 0; ly = 0; frames = 0;
            e_miss = 0; e_sof = 0; e_eeol = 0; e_leol = 0;
            fd_pending = 0; stalled = 0; lat_pend = 0;
        end else begin
            got_beat = {m_tuser, m_tlast, m_tdata};
            check_eq("frame_done", frame_done, fd_pending);
            fd_pending = 1'b0;
            if (lat_pend) begin
                check_eq("latency_valid", m_tvalid, 1);
                check_eq("latency_beat", got_beat, lat_beat);
            end
            if (stalled) begin
                check_eq("stall_valid", m_tvalid, 1);
                check_eq("stall_beat", got_beat, stall_beat);
            end
            if (m_tvalid && m_tready) begin
                check_eq("out_beat_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("out_beat", got_beat, exp_q.pop_front());
            end
            stalled    = m_tvalid && !m_tready;
            stall_beat = got_beat;
            if (clear_errors) begin
                e_miss = 0; e_sof = 0; e_eeol = 0; e_leol = 0;
            end
            lat_pend = 1'b0;
            if (s_tvalid && s_tready) begin
                beat = {s_tuser, s_tlast, s_tdata};
                exp_q.push_back(beat);
                model_beat(s_tuser, s_tlast);
                if (m_tready) begin
                    lat_pend = 1'b1;
                    lat_beat = beat;
                end
            end
        end
    end

    // Downstream ready: 0 = always high, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int p = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       m_tready = (p % 4 == 0) || (p % 4 == 3);
                2:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b1;
            endcase
            p++;
        end
    end

    task automatic send_beat(input bit u, input bit l, input int idle);
        bit ok = 1'b0;
        repeat (idle) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = DW'($urandom);
        s_tuser  = u;
        s_tlast  = l;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
        end
        check_eq("send_accept", ok, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_line(input bit sof, input int n);
        for (int i = 0; i < n; i++) send_beat(sof && i == 0, i == n - 1, $urandom_range(0, 2));
    endtask

    task automatic send_frame();
        for (int i = 0; i < H; i++) send_line(i == 0, B);
    endtask

    task automatic do_clear();
        clear_errors = 1'b1;
        @(posedge clk);
        #1;
        clear_errors = 1'b0;
    endtask

    task automatic end_check(input string tag);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        check_eq({tag, "_missing_sof"}, err_missing_sof, e_miss);
        check_eq({tag, "_early_sof"}, err_early_sof, e_sof);
        check_eq({tag, "_early_eol"}, err_early_eol, e_eeol);
        check_eq({tag, "_late_eol"}, err_late_eol, e_leol);
        check_eq({tag, "_frame_count"}, frame_count, 16'(frames));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_s_tready"}, s_tready, 0);
        check_eq({tag, "_m_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_m_payload"}, {m_tuser, m_tlast, m_tdata}, 0);
        check_eq({tag, "_errs"}, {err_missing_sof, err_early_sof, err_early_eol, err_late_eol}, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean frame, downstream always ready.
        rmode = 0;
        send_frame();
        end_check("clean");
        check_eq("clean_count_is_1", frame_count, 1);

        // Clean frame with 1,0,0,1 backpressure.
        rmode = 1;
        send_frame();
        end_check("bp");

        // Line 1 closes at beat 2.
        rmode = 0;
        do_clear();
        send_line(1, B);
        send_line(0, 3);
        send_line(0, B);
        send_line(0, B);
        end_check("early_eol");
        check_eq("early_eol_flag", err_early_eol, 1);

        // Line 0 runs to beat 5.
        do_clear();
        send_line(1, 6);
        for (int i = 1; i < H; i++) send_line(0, B);
        end_check("late_eol");
        check_eq("late_eol_flag", err_late_eol, 1);

        // Reset, two orphan beats, clean frame, then SOF inside line 2.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 2;
        send_beat(0, 0, 0);
        send_beat(0, 0, 1);
        send_frame();
        end_check("missing_sof");
        check_eq("missing_sof_flag", err_missing_sof, 1);
        send_line(1, B);
        send_line(0, B);
        send_line(1, B);
        end_check("early_sof_restart");
        for (int i = 1; i < H; i++) send_line(0, B);
        end_check("early_sof_done");
        check_eq("early_sof_flag", err_early_sof, 1);

        // Clear coinciding with a fresh missing-SOF error keeps that flag.
        rmode = 0;
        clear_errors = 1'b1;
        send_beat(0, 0, 0);
        clear_errors = 1'b0;
        end_check("clear_same_cycle");
        check_eq("clear_keeps_new", err_missing_sof, 1);
        do_clear();
        end_check("clear");

        // Reset for one cycle in the middle of line 2.
        rmode = 2;
        send_line(1, B);
        send_line(0, B);
        send_beat(0, 0, 0);
        send_beat(0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", s_tready, 0);
        send_frame();
        end_check("after_reset");
        check_eq("after_reset_count", frame_count, 1);

        // Random lines of random length with occasional SOF.
        for (int i = 0; i < 40; i++) send_line(i == 0 || $urandom_range(0, 7) == 0,
                                               $urandom_range(1, 6));
        end_check("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_video_frame_checker.md
AXIS_VIDEO_FRAME_CHECKER -- requirements
Module: axis_video_frame_checker

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 960, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 540, lines per frame.
REQ-003 SHALL have parameter PIXEL_PER_CLK, default 1, pixels per beat; legal values 1, 2, 4, 8; IMAGE_WIDTH SHALL be a multiple of it.
REQ-004 SHALL have parameter BITS_PER_PIXEL, default 32, pixel width; DW = BITS_PER_PIXEL*PIXEL_PER_CLK; BEATS = IMAGE_WIDTH/PIXEL_PER_CLK.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_axis_video_in_tdata/tvalid/tlast/tuser, input, DW/1/1/1; upstream video stream (tuser = SOF, tlast = EOL).
REQ-008 SHALL have port s_axis_video_in_tready, output, 1, upstream backpressure.
REQ-009 SHALL have ports m_axis_video_out_tdata/tvalid/tlast/tuser, output, DW/1/1/1; downstream stream.
REQ-010 SHALL have port m_axis_video_out_tready, input, 1, downstream backpressure.
REQ-011 SHALL have port clear_errors, input, 1, synchronous single-cycle clear of sticky error flags.
REQ-012 SHALL have ports err_missing_sof, err_early_sof, err_early_eol, err_late_eol, output, 1 each, sticky error flags.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse per completed frame.
REQ-014 SHALL have port frame_count, output, 16, completed frames, wraps 0xFFFF->0.

Function
REQ-015 Datapath SHALL be a 2-entry skid register slice: tdata/tlast/tuser forwarded unmodified, in order, no loss or duplication; latency 1 cycle from input handshake to m tvalid.
REQ-016 s_axis_video_in_tready SHALL be driven from a register (no combinational path from m_axis_video_out_tready); full throughput 1 beat/cycle when downstream ready is held high.
REQ-017 m_axis_video_out_tvalid and payload SHALL stay stable while tvalid=1 and tready=0.
REQ-018 Checker SHALL evaluate only input handshake beats (s tvalid & s tready); beat counter x (0..BEATS, saturating at BEATS) and line counter y (0..IMAGE_HEIGHT-1).
REQ-019 FSM states: WAIT_SOF (reset state), IN_FRAME.
REQ-020 WAIT_SOF, beat with tuser=0: set err_missing_sof; counters unchanged; stay.
REQ-021 WAIT_SOF, beat with tuser=1: treat as beat 0 of line 0; go IN_FRAME.
REQ-022 IN_FRAME, beat with tuser=1: set err_early_sof; restart frame with this beat as beat 0 of line 0 (x, y reset); frame_count unchanged.
REQ-023 IN_FRAME, beat with tlast=1 and beat index != BEATS-1: set err_early_eol if index < BEATS-1, err_late_eol if index > BEATS-1; the line still closes.
REQ-024 Any beat at index BEATS-1 with tlast=0 SHALL set err_late_eol on that beat; the line stays open until tlast.
REQ-025 Line close: x=0, y=y+1; close of line IMAGE_HEIGHT-1 SHALL pulse frame_done on the next cycle, increment frame_count, clear y, and return to WAIT_SOF.
REQ-026 A single beat with tuser=1 and tlast=1 SHALL apply REQ-021/022 first, then REQ-023 (BEATS=1 -> no error).
REQ-027 Error flags SHALL be sticky; clear_errors clears them; a new error in the same cycle as clear_errors SHALL leave that flag set.
REQ-028 Errors SHALL NOT alter the forwarded stream.

Reset
REQ-029 While rst_n=0: s tready=0, m tvalid=0, m tdata/tlast/tuser=0, skid buffer empty, FSM=WAIT_SOF, x=y=0, all err flags=0, frame_done=0, frame_count=0.
REQ-030 Reset asserted mid-frame SHALL discard buffered beats; s tready SHALL rise no earlier than the first clk edge after rst_n deasserts.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, PIXEL_PER_CLK=2, BEATS=4)
REQ-031 Clean 16-beat frame, m tready=1 -> output identical to input, 1-cycle latency, frame_done pulse once, frame_count=1, no errors.
REQ-032 Same frame, m tready toggled 1,0,0,1 repeating -> no lost/duplicated/reordered beats; payload stable while stalled.
REQ-033 Line 1 tlast at beat 2 -> err_early_eol=1 only; line 2 starts next beat; frame completes, frame_count=1.
REQ-034 Line 0 without tlast at beat 3, tlast at beat 5 -> err_late_eol=1; line closes at beat 5; other flags 0.
REQ-035 Two beats without tuser after reset, then clean frame -> err_missing_sof=1, frame_count=1; tuser on line 2 of next frame -> err_early_sof=1, frame restarts, count stays until 16 further beats.
REQ-036 rst_n low for 1 cycle mid-frame at line 2 -> all outputs at reset values; subsequent clean frame gives frame_count=1, no errors.
